jtag_tap_sampled: RTL and testbench

Oversampled IEEE 1149.1 TAP responder that runs entirely in the system clock domain, for targets that cannot route TCK as a clock. It samples TCK/TMS/TDI as ordinary inputs, runs the 16-state TAP controller on detected TCK edges, and implements three data registers: IDCODE, BYPASS and a 32-bit USER register with a parallel system-side port. It answers the same JTAG initiator that drives the `jtag_tap` / `adv_dbg_if` chain.

---
 rtl/jtag_tap_sampled.sv | 166 ++++++++++++++++
 tb/tb_jtag_tap_sampled.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_tap_sampled.sv
// IEEE 1149.1 TAP responder running entirely in the system clock domain.
// TCK/TMS/TDI are oversampled, and the TAP advances on detected TCK edges.
module jtag_tap_sampled #(
  parameter logic [31:0] IDCODE_VALUE = 32'h149511C3,
  parameter int          IR_LEN       = 4
) (
  input  logic        sys_clk_i,
  input  logic        sys_rst_n_i,
  input  logic        tck_pad_i,
  input  logic        tms_pad_i,
  input  logic        tdi_pad_i,
  output logic        tdo_pad_o,
  output logic        tdo_padoe_o,
  input  logic [31:0] user_data_i,
  output logic [31:0] user_data_o,
  output logic        user_update_o,
  output logic [3:0]  tap_state_o
);

  typedef enum logic [3:0] {
    TLR     = 4'd0,
    RTI     = 4'd1,
    SEL_DR  = 4'd2,
    CAP_DR  = 4'd3,
    SH_DR   = 4'd4,
    EX1_DR  = 4'd5,
    PAU_DR  = 4'd6,
    EX2_DR  = 4'd7,
    UPD_DR  = 4'd8,
    SEL_IR  = 4'd9,
    CAP_IR  = 4'd10,
    SH_IR   = 4'd11,
    EX1_IR  = 4'd12,
    PAU_IR  = 4'd13,
    EX2_IR  = 4'd14,
    UPD_IR  = 4'd15
  } tapState_t;

  localparam logic [IR_LEN-1:0] IR_IDCODE = 4'h1;
  localparam logic [IR_LEN-1:0] IR_USER   = 4'h8;

  logic r_tckMeta, r_tckSync, r_tckPrev;
  logic r_tmsMeta, r_tmsSync;
  logic r_tdiMeta, r_tdiSync;
  logic w_rise, w_fall;

  tapState_t r_state, w_nextState;

  logic [IR_LEN-1:0] r_ir, r_irShift;
  logic [31:0]       r_drShift;
  logic              w_isBypass;
  logic              r_tdo, r_tdoOe, r_userUpdate;
  logic [31:0]       r_userData;

  // TMS and TDI share the TCK synchronizer depth so they line up with the detected edge.
  always_ff @(posedge sys_clk_i) begin
    if (!sys_rst_n_i) begin
      r_tckMeta <= 1'b0;
      r_tckSync <= 1'b0;
      r_tckPrev <= 1'b0;
      r_tmsMeta <= 1'b0;
      r_tmsSync <= 1'b0;
      r_tdiMeta <= 1'b0;
      r_tdiSync <= 1'b0;
    end else begin
      r_tckMeta <= tck_pad_i;
      r_tckSync <= r_tckMeta;
      r_tckPrev <= r_tckSync;
      r_tmsMeta <= tms_pad_i;
      r_tmsSync <= r_tmsMeta;
      r_tdiMeta <= tdi_pad_i;
      r_tdiSync <= r_tdiMeta;
    end
  end

  assign w_rise     = r_tckSync & ~r_tckPrev;
  assign w_fall     = ~r_tckSync & r_tckPrev;
  assign w_isBypass = (r_ir != IR_IDCODE) && (r_ir != IR_USER);

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      TLR:     w_nextState = r_tmsSync ? TLR    : RTI;
      RTI:     w_nextState = r_tmsSync ? SEL_DR : RTI;
      SEL_DR:  w_nextState = r_tmsSync ? SEL_IR : CAP_DR;
      CAP_DR:  w_nextState = r_tmsSync ? EX1_DR : SH_DR;
      SH_DR:   w_nextState = r_tmsSync ? EX1_DR : SH_DR;
      EX1_DR:  w_nextState = r_tmsSync ? UPD_DR : PAU_DR;
      PAU_DR:  w_nextState = r_tmsSync ? EX2_DR : PAU_DR;
      EX2_DR:  w_nextState = r_tmsSync ? UPD_DR : SH_DR;
      UPD_DR:  w_nextState = r_tmsSync ? SEL_DR : RTI;
      SEL_IR:  w_nextState = r_tmsSync ? TLR    : CAP_IR;
      CAP_IR:  w_nextState = r_tmsSync ? EX1_IR : SH_IR;
      SH_IR:   w_nextState = r_tmsSync ? EX1_IR : SH_IR;
      EX1_IR:  w_nextState = r_tmsSync ? UPD_IR : PAU_IR;
      PAU_IR:  w_nextState = r_tmsSync ? EX2_IR : PAU_IR;
      EX2_IR:  w_nextState = r_tmsSync ? UPD_IR : SH_IR;
      UPD_IR:  w_nextState = r_tmsSync ? SEL_DR : RTI;
      default: w_nextState = TLR;
    endcase
  end

  // Capture/shift act on the TCK rise; TDO and the update registers move on the fall.
  always_ff @(posedge sys_clk_i) begin
    if (!sys_rst_n_i) begin
      r_state      <= TLR;
      r_ir         <= IR_IDCODE;
      r_irShift    <= '0;
      r_drShift    <= '0;
      r_tdo        <= 1'b0;
      r_tdoOe      <= 1'b0;
      r_userData   <= '0;
      r_userUpdate <= 1'b0;
    end else begin
      r_userUpdate <= 1'b0;
      if (w_rise) begin
        r_state <= w_nextState;
        r_tdoOe <= (w_nextState == SH_DR) || (w_nextState == SH_IR);
        if (w_nextState == TLR) begin
          r_ir <= IR_IDCODE;
        end
        case (r_state)
          CAP_IR: r_irShift <= 4'b0101;
          SH_IR:  r_irShift <= {r_tdiSync, r_irShift[IR_LEN-1:1]};
          CAP_DR: begin
            if (r_ir == IR_IDCODE) begin
              r_drShift <= IDCODE_VALUE;
            end else if (r_ir == IR_USER) begin
              r_drShift <= user_data_i;
            end else begin
              r_drShift <= '0;
            end
          end
          SH_DR: begin
            if (w_isBypass) begin
              r_drShift[0] <= r_tdiSync;
            end else begin
              r_drShift <= {r_tdiSync, r_drShift[31:1]};
            end
          end
          default: ;
        endcase
      end else if (w_fall) begin
        case (r_state)
          SH_IR:  r_tdo <= r_irShift[0];
          SH_DR:  r_tdo <= r_drShift[0];
          UPD_IR: r_ir  <= r_irShift;
          UPD_DR: begin
            if (r_ir == IR_USER) begin
              r_userData   <= r_drShift;
              r_userUpdate <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign tdo_pad_o     = r_tdo;
  assign tdo_padoe_o   = r_tdoOe;
  assign user_data_o   = r_userData;
  assign user_update_o = r_userUpdate;
  assign tap_state_o   = r_state;

endmodule

// File: tb/tb_jtag_tap_sampled.sv
// Self-checking bench for jtag_tap_sampled: bit-banged TCK with directed scans
// and a state/enable vector table for an IR load.
module tb_jtag_tap_sampled;

  logic        sysClk = 1'b0;
  logic        sysRstN = 1'b0;
  logic        tck = 1'b0;
  logic        tms = 1'b1;
  logic        tdi = 1'b0;
  logic        tdo, tdoOe, userUpdate;
  logic [31:0] userDataIn = 32'h0;
  logic [31:0] userDataOut;
  logic [3:0]  tapState;

  int checks = 0;
  int errors = 0;
  int updPulses = 0;
  int updHigh = 0;
  logic updPrev = 1'b0;

  typedef struct {
    logic       tms;
    logic       tdi;
    logic [3:0] expState;
    logic       expOe;
    logic       chkTdo;
    logic       expTdo;
  } vec_t;

  vec_t irVecs[10];

  always #5 sysClk = ~sysClk;

  jtag_tap_sampled dut (
    .sys_clk_i    (sysClk),
    .sys_rst_n_i  (sysRstN),
    .tck_pad_i    (tck),
    .tms_pad_i    (tms),
    .tdi_pad_i    (tdi),
    .tdo_pad_o    (tdo),
    .tdo_padoe_o  (tdoOe),
    .user_data_i  (userDataIn),
    .user_data_o  (userDataOut),
    .user_update_o(userUpdate),
    .tap_state_o  (tapState)
  );

  // Count update pulses and total high cycles; equal totals mean every pulse was one cycle wide.
  always @(negedge sysClk) begin
    if (userUpdate === 1'b1) begin
      updHigh++;
      if (updPrev !== 1'b1) updPulses++;
    end
    updPrev = userUpdate;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // One full TCK period; returns TDO as it stands after the falling edge.
  task automatic applyStimulus(input logic tmsVal, input logic tdiVal, output logic tdoVal);
    tms = tmsVal;
    tdi = tdiVal;
    repeat (4) @(negedge sysClk);
    tck = 1'b1;
    repeat (8) @(negedge sysClk);
    tck = 1'b0;
    repeat (8) @(negedge sysClk);
    tdoVal = tdo;
  endtask

  task automatic dataScan(input logic [31:0] tdiWord, input int nBits,
                          output logic [31:0] tdoWord, output int oeErr);
    logic b;
    tdoWord = 32'h0;
    oeErr = 0;
    applyStimulus(1'b1, 1'b0, b); if (tdoOe !== 1'b0) oeErr++;
    applyStimulus(1'b0, 1'b0, b); if (tdoOe !== 1'b0) oeErr++;
    applyStimulus(1'b0, 1'b0, b); tdoWord[0] = b; if (tdoOe !== 1'b1) oeErr++;
    for (int i = 0; i < nBits - 1; i++) begin
      applyStimulus(1'b0, tdiWord[i], b);
      tdoWord[i+1] = b;
      if (tdoOe !== 1'b1) oeErr++;
    end
    applyStimulus(1'b1, tdiWord[nBits-1], b); if (tdoOe !== 1'b0) oeErr++;
    applyStimulus(1'b1, 1'b0, b); if (tdoOe !== 1'b0) oeErr++;
    applyStimulus(1'b0, 1'b0, b); if (tdoOe !== 1'b0) oeErr++;
  endtask

  task automatic irScan(input logic [3:0] irVal, output logic [3:0] captured);
    logic b;
    captured = 4'h0;
    applyStimulus(1'b1, 1'b0, b);
    applyStimulus(1'b1, 1'b0, b);
    applyStimulus(1'b0, 1'b0, b);
    applyStimulus(1'b0, 1'b0, b); captured[0] = b;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, irVal[i], b);
      captured[i+1] = b;
    end
    applyStimulus(1'b1, irVal[3], b);
    applyStimulus(1'b1, 1'b0, b);
    applyStimulus(1'b0, 1'b0, b);
  endtask

  initial begin
    logic        b;
    logic [31:0] word;
    logic [3:0]  cap;
    int          oeErr;
    int          pulsesBefore;

    // IR load of USER (4'h8) starting from Run-Test/Idle.
    irVecs[0] = '{1'b1, 1'b0, 4'd2,  1'b0, 1'b0, 1'b0};
    irVecs[1] = '{1'b1, 1'b0, 4'd9,  1'b0, 1'b0, 1'b0};
    irVecs[2] = '{1'b0, 1'b0, 4'd10, 1'b0, 1'b0, 1'b0};
    irVecs[3] = '{1'b0, 1'b0, 4'd11, 1'b1, 1'b1, 1'b1};
    irVecs[4] = '{1'b0, 1'b0, 4'd11, 1'b1, 1'b1, 1'b0};
    irVecs[5] = '{1'b0, 1'b0, 4'd11, 1'b1, 1'b1, 1'b1};
    irVecs[6] = '{1'b0, 1'b0, 4'd11, 1'b1, 1'b1, 1'b0};
    irVecs[7] = '{1'b1, 1'b1, 4'd12, 1'b0, 1'b1, 1'b0};
    irVecs[8] = '{1'b1, 1'b0, 4'd15, 1'b0, 1'b0, 1'b0};
    irVecs[9] = '{1'b0, 1'b0, 4'd1,  1'b0, 1'b0, 1'b0};

    repeat (4) @(negedge sysClk);
    checkOutput("reset state", 32'(tapState), 32'd0);
    checkOutput("reset tdo", 32'(tdo), 32'd0);
    checkOutput("reset tdoOe", 32'(tdoOe), 32'd0);
    checkOutput("reset userData", userDataOut, 32'h0);
    checkOutput("reset userUpdate", 32'(userUpdate), 32'd0);
    sysRstN = 1'b1;
    repeat (4) @(negedge sysClk);

    // IDCODE read straight out of reset
    applyStimulus(1'b0, 1'b0, b);
    checkOutput("tlr to rti", 32'(tapState), 32'd1);
    dataScan(32'h0, 32, word, oeErr);
    checkOutput("idcode tdo", word, 32'h149511C3);
    checkOutput("idcode oe", 32'(oeErr), 32'd0);
    checkOutput("idcode end state", 32'(tapState), 32'd1);
    checkOutput("idcode no update", 32'(updPulses), 32'd0);

    for (int i = 0; i < 10; i++) begin
      applyStimulus(irVecs[i].tms, irVecs[i].tdi, b);
      checkOutput($sformatf("irVec%0d state", i), 32'(tapState), 32'(irVecs[i].expState));
      checkOutput($sformatf("irVec%0d oe", i), 32'(tdoOe), 32'(irVecs[i].expOe));
      if (irVecs[i].chkTdo) checkOutput($sformatf("irVec%0d tdo", i), 32'(b), 32'(irVecs[i].expTdo));
    end

    // USER capture/update in one scan
    userDataIn = 32'h12345678;
    pulsesBefore = updPulses;
    dataScan(32'hDEADBEEF, 32, word, oeErr);
    checkOutput("user tdo", word, 32'h12345678);
    checkOutput("user oe", 32'(oeErr), 32'd0);
    checkOutput("user data out", userDataOut, 32'hDEADBEEF);
    checkOutput("user one pulse", 32'(updPulses - pulsesBefore), 32'd1);

    // Unassigned IR code falls back to BYPASS
    irScan(4'h3, cap);
    checkOutput("ir capture 0101", 32'(cap), 32'h5);
    pulsesBefore = updPulses;
    dataScan(32'h000000A5, 9, word, oeErr);
    checkOutput("bypass tdo", word, 32'h0000014A);
    checkOutput("bypass oe", 32'(oeErr), 32'd0);
    checkOutput("bypass no update", 32'(updPulses - pulsesBefore), 32'd0);
    checkOutput("bypass userData held", userDataOut, 32'hDEADBEEF);

    // Five TMS=1 from Shift-DR under USER: walks through Update-DR once
    irScan(4'h8, cap);
    applyStimulus(1'b1, 1'b0, b);
    applyStimulus(1'b0, 1'b0, b);
    applyStimulus(1'b0, 1'b0, b);
    checkOutput("tlr walk in shdr", 32'(tapState), 32'd4);
    pulsesBefore = updPulses;
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, b);
    checkOutput("tlr walk state", 32'(tapState), 32'd0);
    checkOutput("tlr walk pulses", 32'(updPulses - pulsesBefore), 32'd1);
    checkOutput("tlr walk userData", userDataOut, 32'h091A2B3C);
    applyStimulus(1'b0, 1'b0, b);
    dataScan(32'h0, 32, word, oeErr);
    checkOutput("tlr ir idcode", word, 32'h149511C3);

    // Reset pulse in the middle of a USER shift
    irScan(4'h8, cap);
    userDataIn = 32'hFFFFFFFF;
    applyStimulus(1'b1, 1'b0, b);
    applyStimulus(1'b0, 1'b0, b);
    applyStimulus(1'b0, 1'b0, b);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, b);
    checkOutput("pre-reset tdo", 32'(tdo), 32'd1);
    checkOutput("pre-reset oe", 32'(tdoOe), 32'd1);
    pulsesBefore = updPulses;
    sysRstN = 1'b0;
    @(negedge sysClk);
    sysRstN = 1'b1;
    checkOutput("midreset state", 32'(tapState), 32'd0);
    checkOutput("midreset tdo", 32'(tdo), 32'd0);
    checkOutput("midreset oe", 32'(tdoOe), 32'd0);
    checkOutput("midreset userData", userDataOut, 32'h0);
    checkOutput("midreset userUpdate", 32'(userUpdate), 32'd0);
    repeat (4) @(negedge sysClk);
    applyStimulus(1'b0, 1'b0, b);
    checkOutput("post-reset rti", 32'(tapState), 32'd1);
    checkOutput("post-reset userData", userDataOut, 32'h0);
    checkOutput("post-reset no pulse", 32'(updPulses - pulsesBefore), 32'd0);
    dataScan(32'h0, 32, word, oeErr);
    checkOutput("post-reset idcode", word, 32'h149511C3);

    checkOutput("pulse width", 32'(updHigh), 32'(updPulses));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
